// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//   Shares one single-port framebuffer RAM between the VGA pixel-fetch path
//   (reader) and the audio-visualizer bar renderer (writer).
//   - Reads win during active video, writes win during blanking.
//   - A saturating wait counter forces a write grant when the writer has
//     waited STARVE_MAX cycles. The forced write displaces a pending read,
//     which is reported on rd_drop.
//   - Every write is followed by one recovery cycle in which no write is
//     granted, so the writer can drop or update wr_req after wr_ack.
//   - Inputs are sampled on a clock edge. The resulting grant appears on
//     the registered mem_* outputs from that edge onward.
//
// Optional feature (macro VSYNC_LOCK_EN):
//   When defined, a write is granted only if vblank=1 at the decision edge
//   (tear-free updates). The forced-write path is disabled, rd_drop stays 0,
//   and the counter still runs and reports saturation on wr_starve.
//   When undefined, vblank is ignored.
//
// Ports:
//   clk        pixel-domain clock
//   rst        asynchronous reset, active low
//   vid_active active-video flag from the timing generator
//   vblank     vertical-blanking flag from the timing generator
//   rd_req     pixel fetch request, rd_addr its address
//   rd_valid   RAM read data valid, RD_LAT cycles after a granted read
//   rd_drop    pulse: a pending read lost to a forced write
//   wr_req     write request, held until wr_ack; wr_addr/wr_data its payload
//   wr_ack     pulse: write issued this cycle
//   wr_starve  write-wait counter is saturated
//   mem_en, mem_we, mem_addr, mem_wdata   single-port RAM interface
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 12,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_active,
  input  logic              vblank,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              rd_drop,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_starve,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_REC
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [RD_LAT-1:0] rd_pipe;
  logic              wr_ok;    // write may be granted by the normal rules
  logic              forced;   // starvation overrides the normal rules

  assign wr_starve = (wait_cnt == CNT_W'(STARVE_MAX));
  assign rd_valid  = rd_pipe[RD_LAT-1];

`ifdef VSYNC_LOCK_EN
  assign wr_ok  = wr_req & vblank;
  assign forced = 1'b0;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign wr_ok  = wr_req;
  assign forced = wr_starve & wr_req;
`endif

  // Grant decision for the next cycle.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt; no latch is inferred.
    state_nxt = S_IDLE;
    if (state == S_WR) begin
      state_nxt = S_REC;
    end else if (forced) begin
      state_nxt = S_WR;
    end else if (vid_active) begin
      if (rd_req)                         state_nxt = S_RD;
      else if (wr_ok && state != S_REC)   state_nxt = S_WR;
    end else begin
      if (wr_ok && state != S_REC)        state_nxt = S_WR;
      else if (rd_req)                    state_nxt = S_RD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      rd_drop   <= 1'b0;
      wait_cnt  <= '0;
      // NOTE: the read-valid pipe is a few flops, not a RAM; clearing it on
      // reset is what keeps a stale rd_valid from escaping after reset.
      rd_pipe   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge values of the others.
      state   <= state_nxt;
      mem_en  <= (state_nxt == S_RD) || (state_nxt == S_WR);
      mem_we  <= (state_nxt == S_WR);
      wr_ack  <= (state_nxt == S_WR);
      rd_drop <= (state_nxt == S_WR) && forced && rd_req;

      // Address/data only change when an access is issued; they hold
      // through idle and recovery cycles.
      if (state_nxt == S_RD) begin
        mem_addr <= rd_addr;
      end else if (state_nxt == S_WR) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end

      // Counts cycles the writer spends waiting; the write cycle itself
      // does not count.
      if ((state_nxt == S_WR) || !wr_req) begin
        wait_cnt <= '0;
      end else if ((state != S_WR) && !wr_starve) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      // Stage 0 marks the cycle after a read issue; the last stage is
      // exactly RD_LAT cycles after it.
      rd_pipe[0] <= (state == S_RD);
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter
//   Directed bench for vga_fb_arbiter. Two instances share the inputs:
//   u_a uses the default parameters (RD_LAT=2, STARVE_MAX=64) and u_b uses
//   RD_LAT=3, STARVE_MAX=4. Inputs change 1 time unit after a rising edge,
//   outputs are sampled at the same point, so each sample shows the grant
//   decided at the preceding edge.
//   Flag vectors are {mem_en, mem_we, wr_ack, rd_drop, wr_starve, rd_valid}.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_active, vblank, rd_req, wr_req;
  logic [14:0] rd_addr, wr_addr;
  logic [11:0] wr_data;

  logic        a_rd_valid, a_rd_drop, a_wr_ack, a_wr_starve, a_mem_en, a_mem_we;
  logic [14:0] a_mem_addr;
  logic [11:0] a_mem_wdata;
  logic        b_rd_valid, b_rd_drop, b_wr_ack, b_wr_starve, b_mem_en, b_mem_we;
  logic [14:0] b_mem_addr;
  logic [11:0] b_mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  wire [5:0] a_flags = {a_mem_en, a_mem_we, a_wr_ack, a_rd_drop, a_wr_starve, a_rd_valid};
  wire [5:0] b_flags = {b_mem_en, b_mem_we, b_wr_ack, b_rd_drop, b_wr_starve, b_rd_valid};

  always #5 clk = ~clk;

  vga_fb_arbiter #(.ADDR_W(15), .DATA_W(12), .RD_LAT(2), .STARVE_MAX(64)) u_a (
    .clk(clk), .rst(rst), .vid_active(vid_active), .vblank(vblank),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(a_rd_valid), .rd_drop(a_rd_drop),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(a_wr_ack),
    .wr_starve(a_wr_starve), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata)
  );

  vga_fb_arbiter #(.ADDR_W(15), .DATA_W(12), .RD_LAT(3), .STARVE_MAX(4)) u_b (
    .clk(clk), .rst(rst), .vid_active(vid_active), .vblank(vblank),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(b_rd_valid), .rd_drop(b_rd_drop),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(b_wr_ack),
    .wr_starve(b_wr_starve), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vid_active = 1'b0;
    vblank     = 1'b0;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
  endtask

  // Called 1 unit after an edge; reset pulse ends well before the next edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    idle_inputs();
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;

    // Reset state
    #2;
    check("rst_a_flags", 32'(a_flags), 32'h0);
    check("rst_a_addr",  32'(a_mem_addr), 32'h0);
    check("rst_a_wdata", 32'(a_mem_wdata), 32'h0);
    check("rst_b_flags", 32'(b_flags), 32'h0);
    #5;
    rst = 1'b1;

    // Test 1: active video, reads and writes both held for 10 cycles.
    // Reads win every cycle, no write, rd_valid 2 cycles after each read.
    vid_active = 1'b1;
    rd_req     = 1'b1;
    wr_req     = 1'b1;
    wr_addr    = 15'h0001;
    wr_data    = 12'h001;
    for (int i = 0; i < 10; i++) begin
      rd_addr = 15'(100 + i);
      step();
      check($sformatf("t1_flags_%0d", i), 32'(a_flags), (i >= 2) ? 32'b100001 : 32'b100000);
      check($sformatf("t1_addr_%0d", i), 32'(a_mem_addr), 32'(100 + i));
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    step();
    check("t1_tail0_flags", 32'(a_flags), 32'b000001);
    check("t1_tail0_hold",  32'(a_mem_addr), 32'd109);
    step();
    check("t1_tail1_flags", 32'(a_flags), 32'b000001);
    step();
    check("t1_tail2_flags", 32'(a_flags), 32'b000000);

    // Tests 2 and 6: blanking, read and write both pending.
    // WR -> REC -> RD (REC serves the read) -> WR again.
    vid_active = 1'b0;
    vblank     = 1'b1;
    rd_req     = 1'b1;
    rd_addr    = 15'h0055;
    wr_req     = 1'b1;
    wr_addr    = 15'h1234;
    wr_data    = 12'hF0A;
    step();
    check("t2_wr1_flags", 32'(a_flags), 32'b111000);
    check("t2_wr1_addr",  32'(a_mem_addr), 32'h1234);
    check("t2_wr1_wdata", 32'(a_mem_wdata), 32'hF0A);
    wr_addr = 15'h0ABC;
    wr_data = 12'h00F;
    step();
    check("t2_rec_flags", 32'(a_flags), 32'b000000);
    check("t2_rec_addr",  32'(a_mem_addr), 32'h1234);
    step();
    check("t2_rd_flags", 32'(a_flags), 32'b100000);
    check("t2_rd_addr",  32'(a_mem_addr), 32'h0055);
    check("t2_rd_wdata", 32'(a_mem_wdata), 32'hF0A);
    step();
    check("t2_wr2_flags", 32'(a_flags), 32'b111000);
    check("t2_wr2_addr",  32'(a_mem_addr), 32'h0ABC);
    check("t2_wr2_wdata", 32'(a_mem_wdata), 32'h00F);
    rd_req = 1'b0;
    wr_req = 1'b0;
    step();
    check("t2_rec2_flags", 32'(a_flags), 32'b000001);
    step();
    check("t2_idle_flags", 32'(a_flags), 32'b000000);

`ifndef VSYNC_LOCK_EN
    // vblank is ignored: a blanking write is granted with vblank=0.
    vblank = 1'b0;
    wr_req = 1'b1;
    wr_addr = 15'h0042;
    step();
    check("novs_wr_flags", 32'(a_flags), 32'b111000);
    check("novs_wr_addr",  32'(a_mem_addr), 32'h0042);
    wr_req = 1'b0;
    step();

    // Test 3: u_b (STARVE_MAX=4, RD_LAT=3), continuous read+write in
    // active video. Starve after 4 cycles, forced write with rd_drop next.
    do_reset();
    vid_active = 1'b1;
    rd_req     = 1'b1;
    wr_req     = 1'b1;
    wr_addr    = 15'h0777;
    wr_data    = 12'h123;
    for (int i = 1; i <= 4; i++) begin
      rd_addr = 15'(16'h0200 + i);
      step();
      case (i)
        1, 2, 3: check($sformatf("t3_b_rd_%0d", i), 32'(b_flags), 32'b100000);
        default: check("t3_b_starve", 32'(b_flags), 32'b100011);
      endcase
    end
    step();
    check("t3_b_forced_flags", 32'(b_flags), 32'b111101);
    check("t3_b_forced_addr",  32'(b_mem_addr), 32'h0777);
    check("t3_b_forced_wdata", 32'(b_mem_wdata), 32'h123);
    check("t3_a_no_force",     32'(a_flags), 32'b100001);
    step();
    check("t3_b_rec_flags", 32'(b_flags), 32'b000001);
    step();
    check("t3_b_rd_after", 32'(b_flags), 32'b100001);
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // STARVE_MAX=64 on u_a: saturation at cycle 64, forced write at 65.
    do_reset();
    vid_active = 1'b1;
    rd_req     = 1'b1;
    wr_req     = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 63) check("sat_a_63", 32'(a_flags), 32'b100001);
    end
    check("sat_a_64", 32'(a_flags), 32'b100011);
    step();
    check("sat_a_forced", 32'(a_flags), 32'b111101);
    idle_inputs();
    step();
`else
    // Test 4: writes locked to vblank. 100 cycles with vblank=0 give no
    // write and a saturated counter; raising vblank grants at the next edge.
    do_reset();
    wr_req  = 1'b1;
    wr_addr = 15'h0333;
    wr_data = 12'hABC;
    begin
      int acks = 0;
      for (int i = 0; i < 100; i++) begin
        step();
        if (a_wr_ack || a_rd_drop) acks++;
      end
      check("t4_no_ack",  32'(acks), 32'd0);
      check("t4_starve",  32'(a_flags), 32'b000010);
    end
    vblank = 1'b1;
    step();
    check("t4_vb_flags", 32'(a_flags), 32'b111000);
    check("t4_vb_addr",  32'(a_mem_addr), 32'h0333);
    idle_inputs();
    step();
`endif

    // Test 5: reset during a read burst on u_b (RD_LAT=3); outputs clear
    // at once and no stale rd_valid appears afterwards.
    do_reset();
    vid_active = 1'b1;
    rd_req     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addr = 15'(16'h0300 + i);
      step();
      check($sformatf("t5_burst_%0d", i), 32'(b_flags), 32'b100000);
    end
    rst = 1'b0;
    #1;
    check("t5_rst_b_flags", 32'(b_flags), 32'h0);
    check("t5_rst_b_addr",  32'(b_mem_addr), 32'h0);
    check("t5_rst_a_flags", 32'(a_flags), 32'h0);
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t5_post_%0d", i), 32'(b_flags), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
